// File: rtl/quan_pkg.sv
// Shared widths, decision thresholds and FSM encoding for the G.726 32 kbit/s
// encoder-side adaptive quantizer.
package quan_pkg;

  localparam int DQM_W  = 15;
  localparam int EXP_W  = 4;
  localparam int MANT_W = 7;
  localparam int DL_W   = 11;
  localparam int DLN_W  = 12;
  localparam int K_W    = 3;

  // Entry 0 is the lowest decision threshold; entry 6 guarantees the scan ends.
  localparam logic [6:0][DLN_W-1:0] T_TAB = {
    12'd2048, 12'd400, 12'd349, 12'd300, 12'd246, 12'd178, 12'd80
  };

  localparam logic [DLN_W-1:0] DLN_NEG_LO = 12'd3972;
  localparam logic [DLN_W-1:0] DLN_MID    = 12'd2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_SUB,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/quan_log_norm.sv
// Serial log2 normaliser: shifts the magnitude left one bit per enabled cycle
// until the MSB is set or the exponent reaches zero.
module quan_log_norm
  import quan_pkg::*;
(
  input  logic              clk,
  input  logic              i_start,
  input  logic              i_en,
  input  logic [DQM_W-1:0]  i_dqm,
  output logic              o_done,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-1:0] o_mant
);

  logic [DQM_W-1:0] r_sh;
  logic [EXP_W-1:0] r_e;

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_sh <= i_dqm;
      r_e  <= 4'd14;
    end else if (i_en && !o_done) begin
      r_sh <= {r_sh[DQM_W-2:0], 1'b0};
      r_e  <= r_e - 4'd1;
    end
  end

  assign o_done = r_sh[DQM_W-1] || (r_e == '0);
  assign o_exp  = r_e;
  assign o_mant = r_sh[DQM_W-2 -: MANT_W];

endmodule

// File: rtl/quan_enc_seq.sv
// Sequential ADPCM adaptive quantizer: normalise |D|, subtract Y/4 in the log
// domain, then scan the decision thresholds one per cycle to produce code I.
module quan_enc_seq
  import quan_pkg::*;
#(
  parameter int D_W = 16,
  parameter int Y_W = 13,
  parameter int I_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [D_W-1:0] d_in,
  input  logic        [Y_W-1:0] y_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic        [I_W-1:0] i_out,
  output logic      [DLN_W-1:0] dln_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_t             r_state, w_next;
  logic               r_in_ready, r_out_valid;
  logic [I_W-1:0]     r_i;
  logic [DLN_W-1:0]   r_dln_out;
  logic               r_ds;
  logic [Y_W-1:0]     r_y;
  logic [K_W-1:0]     r_k;

  logic               w_accept, w_load, w_norm_done;
  logic [K_W-1:0]     w_m;
  logic [DQM_W-1:0]   w_dqm;
  logic [EXP_W-1:0]   w_exp;
  logic [MANT_W-1:0]  w_mant;
  logic [DL_W-1:0]    w_dl;
  logic [DLN_W-1:0]   w_dln;

  function automatic logic [I_W-1:0] code_map(input logic [K_W-1:0] m, input logic ds);
    if (m == '0)
      return 4'd15;
    else if (ds)
      return 4'd15 - {1'b0, m};
    else
      return {1'b0, m};
  endfunction

  // Magnitude of the most negative input folds to zero.
  assign w_dqm = d_in[D_W-1] ? DQM_W'(~d_in[DQM_W-1:0] + 15'd1) : d_in[DQM_W-1:0];

  quan_log_norm u_norm (
    .clk     (clk),
    .i_start (w_accept),
    .i_en    (r_state == ST_NORM),
    .i_dqm   (w_dqm),
    .o_done  (w_norm_done),
    .o_exp   (w_exp),
    .o_mant  (w_mant)
  );

  assign w_dl  = {w_exp, w_mant};
  assign w_dln = DLN_W'({2'b00, w_dl} - (r_y >> 2));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_m      = '0;
    case (r_state)
      ST_IDLE: if (in_valid && r_in_ready) begin
        w_accept = 1'b1;
        w_next   = ST_NORM;
      end
      ST_NORM: if (w_norm_done) w_next = ST_SUB;
      ST_SUB: begin
        if (w_dln >= DLN_NEG_LO) begin
          w_m    = 3'd1;
          w_load = 1'b1;
          w_next = ST_DONE;
        end else if (w_dln >= DLN_MID) begin
          w_load = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: if (w_dln < T_TAB[r_k]) begin
        w_m    = K_W'(r_k + 3'd1);
        w_load = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake flags and result registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_i         <= '0;
      r_dln_out   <= '0;
    end else begin
      r_in_ready  <= (w_next == ST_IDLE);
      r_out_valid <= (w_next == ST_DONE);
      if (w_load) begin
        r_i       <= code_map(w_m, r_ds);
        r_dln_out <= w_dln;
      end
    end
  end

  // Sample context and scan index
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ds <= d_in[D_W-1];
      r_y  <= y_in;
    end
    if (r_state == ST_SUB)
      r_k <= '0;
    else if (r_state == ST_SCAN)
      r_k <= K_W'(r_k + 3'd1);
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign i_out     = r_i;
  assign dln_out   = r_dln_out;

endmodule

// File: tb/tb_quan_enc_seq.sv
// Directed vector bench for quan_enc_seq: code, DLN and latency per sample,
// plus output hold under back-pressure and reset while busy.
module tb_quan_enc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d_in;
  logic [12:0] y_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  i_out;
  logic [11:0] dln_out;
  logic        out_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  quan_enc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_out     (i_out),
    .dln_out   (dln_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [12:0] y;
    logic [3:0]  exp_i;
    logic [11:0] exp_dln;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Accept one sample and return edges counted until out_valid rises (-1 on timeout).
  task automatic send(input logic [15:0] d, input logic [12:0] y, output int lat);
    @(negedge clk);
    d_in     = d;
    y_in     = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d_in     = 16'h1234;
    y_in     = 13'h0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, "_ovalid_drop"}, int'(out_valid), 0);
    check({name, "_iready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    logic [3:0] held;

    vecs[0] = '{16'h0000, 13'd0,    4'd1,  12'd0,    17};
    vecs[1] = '{16'h4000, 13'd0,    4'd7,  12'd1792, 9};
    vecs[2] = '{16'hC000, 13'd0,    4'd8,  12'd1792, 9};
    vecs[3] = '{16'h8000, 13'd0,    4'd14, 12'd0,    17};
    vecs[4] = '{16'd100,  13'd2048, 4'd5,  12'd328,  15};
    vecs[5] = '{16'd1,    13'd4096, 4'd15, 12'd3072, 16};
    vecs[6] = '{16'hFFFF, 13'd400,  4'd14, 12'd3996, 16};
    vecs[7] = '{16'h7FFF, 13'd0,    4'd7,  12'd1919, 9};
    vecs[8] = '{16'd10,   13'd100,  4'd6,  12'd391,  19};

    reset     = 1'b0;
    d_in      = '0;
    y_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_i_out", int'(i_out), 0);
    check("rst_dln_out", int'(dln_out), 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[n]) begin
      send(vecs[n].d, vecs[n].y, lat);
      check($sformatf("v%0d_latency", n), lat, vecs[n].exp_lat);
      check($sformatf("v%0d_i_out", n), int'(i_out), int'(vecs[n].exp_i));
      check($sformatf("v%0d_dln_out", n), int'(dln_out), int'(vecs[n].exp_dln));
      check($sformatf("v%0d_in_ready", n), int'(in_ready), 0);
      release_out($sformatf("v%0d", n));
    end

    // Back-pressure: results held, new input ignored while DONE
    send(16'd100, 13'd2048, lat);
    check("hold_latency", lat, 15);
    held = i_out;
    in_valid = 1'b1;
    d_in     = 16'h4000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_i_out", c), int'(i_out), int'(held));
      check($sformatf("hold%0d_in_ready", c), int'(in_ready), 0);
      check($sformatf("hold%0d_out_valid", c), int'(out_valid), 1);
    end
    in_valid = 1'b0;
    check("hold_i_value", int'(i_out), 5);
    release_out("hold");

    // Reset asserted in the middle of NORM
    @(negedge clk);
    d_in     = 16'h0000;
    y_in     = 13'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_in_ready", int'(in_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_i_out", int'(i_out), 0);
    check("midrst_dln_out", int'(dln_out), 0);
    @(negedge clk);
    reset = 1'b1;

    send(16'hC000, 13'd0, lat);
    check("post_rst_latency", lat, 9);
    check("post_rst_i_out", int'(i_out), 8);
    release_out("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
